// File: rtl/mem_256x16.sv
// 256x16 register-file memory: 8 banks of paired 32x8 front/back RAMs.
// Writes are synchronous, reads are combinational, reset clears all words.
module mem_256x16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  MemW_Addr,
    input  logic [15:8] MemW_Data_f,
    input  logic [7:0]  MemW_Data_b,
    input  logic        MemW_en,
    input  logic [2:0]  MemR_Addr,
    output logic [15:0] MemR_Data
);

    logic [7:0] front_q [8][32];
    logic [7:0] back_q  [8][32];

    logic [2:0] wr_bank;
    logic [4:0] wr_word;
    logic [7:0] front_d;
    logic [7:0] back_d;

    assign wr_bank = MemW_Addr[7:5];
    assign wr_word = MemW_Addr[4:0];
    assign front_d = MemW_Data_f;
    assign back_d  = MemW_Data_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 8; b++) begin
                for (int w = 0; w < 32; w++) begin
                    front_q[b][w] <= 8'h00;
                    back_q[b][w]  <= 8'h00;
                end
            end
        end else if (MemW_en) begin
            front_q[wr_bank][wr_word] <= front_d;
            back_q[wr_bank][wr_word]  <= back_d;
        end
    end

    // Read bank comes from its own port; the word index is shared with the write address.
    assign MemR_Data = {front_q[MemR_Addr][wr_word], back_q[MemR_Addr][wr_word]};

endmodule

// File: tb/tb_mem_256x16.sv
// Scoreboard bench for mem_256x16: a reference model feeds an expected
// queue on each read stimulus; the DUT output is popped and compared.
module tb_mem_256x16;

    logic        clk;
    logic        rst_n;
    logic [7:0]  MemW_Addr;
    logic [15:8] MemW_Data_f;
    logic [7:0]  MemW_Data_b;
    logic        MemW_en;
    logic [2:0]  MemR_Addr;
    logic [15:0] MemR_Data;

    mem_256x16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemW_Addr   (MemW_Addr),
        .MemW_Data_f (MemW_Data_f),
        .MemW_Data_b (MemW_Data_b),
        .MemW_en     (MemW_en),
        .MemR_Addr   (MemR_Addr),
        .MemR_Data   (MemR_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] model [256];
    logic [15:0] exp_q [$];
    int n_chk;
    int n_fail;

    task automatic check_eq(input string tag, input logic [15:0] got,
                            input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 256; k++) model[k] = 16'h0000;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] f,
                      input logic [7:0] b);
        @(negedge clk);
        MemW_Addr   = a;
        MemW_Data_f = f;
        MemW_Data_b = b;
        MemW_en     = 1'b1;
        @(posedge clk);
        if (rst_n) model[a] = {f, b};
        @(negedge clk);
        MemW_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] bank,
                      input logic [7:0] a);
        logic [7:0] idx;
        MemR_Addr = bank;
        MemW_Addr = a;
        idx = {bank, a[4:0]};
        exp_q.push_back(model[idx]);
        #1;
        check_eq(tag, MemR_Data, exp_q.pop_front());
    endtask

    task automatic fill();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 32; j++)
                wr({i[2:0], j[4:0]}, i[7:0], j[7:0]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] a;
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        MemW_Addr = 8'h00;
        MemW_Data_f = 8'h00;
        MemW_Data_b = 8'h00;
        MemW_en = 1'b0;
        MemR_Addr = 3'd0;
        model_clear();
        #1;
        rd("reset_b0w0", 3'd0, 8'h00);
        rd("reset_b7w31", 3'd7, 8'hFF);
        rd("reset_b4w9", 3'd4, 8'h29);
        @(negedge clk);
        rst_n = 1'b1;

        fill();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 32; j++)
                rd("fill", i[2:0], {i[2:0], j[4:0]});
        MemR_Addr = 3'd3;
        MemW_Addr = 8'h71;
        #1;
        check_eq("fill_b3w17_const", MemR_Data, 16'h0311);
        // Read bank independent of MemW_Addr[7:5]
        rd("xbank_r2_w5", 3'd2, 8'hA4);
        rd("xbank_r6_w0", 3'd6, 8'h1F);
        rd("xbank_r0_w7", 3'd0, 8'hE3);

        wr(8'h00, 8'hFF, 8'hFF);
        rd("first_loc", 3'd0, 8'h00);
        wr(8'hFF, 8'h55, 8'hAA);
        rd("last_loc", 3'd7, 8'hFF);
        MemR_Addr = 3'd7;
        MemW_Addr = 8'hFF;
        #1;
        check_eq("last_loc_const", MemR_Data, 16'h55AA);
        rd("last_nbr", 3'd7, 8'hFE);
        rd("first_nbr", 3'd1, 8'h20);

        for (int i = 0; i < 8; i++) begin
            wr({i[2:0], 5'h0A}, 8'hA0 + i[7:0], 8'h0A);
            MemR_Addr = i[2:0];
            #1;
            check_eq("bank_sw", MemR_Data, {8'hA0 + i[7:0], 8'h0A});
            for (int k = 0; k < 8; k++)
                rd("bank_sw_other", k[2:0], {i[2:0], 5'h0A});
        end

        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            MemW_Addr = 8'h40 + n[7:0];
            MemW_Data_f = 8'hC3;
            MemW_Data_b = 8'h3C;
            MemW_en = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        for (int n = 0; n < 4; n++)
            rd("wr_dis", 3'd2, 8'h40 + n[7:0]);

        // Same-cycle write and read of one location
        @(negedge clk);
        a = 8'hB5;
        MemW_Addr = a;
        MemW_Data_f = 8'h12;
        MemW_Data_b = 8'h34;
        MemR_Addr = 3'd5;
        MemW_en = 1'b1;
        exp_q.push_back(model[a]);
        #1;
        check_eq("rw_old", MemR_Data, exp_q.pop_front());
        @(posedge clk);
        model[a] = 16'h1234;
        exp_q.push_back(model[a]);
        #1;
        check_eq("rw_new", MemR_Data, exp_q.pop_front());
        @(negedge clk);
        MemW_en = 1'b0;

        fill();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        rd("rst_mid_b3w17", 3'd3, 8'h71);
        rd("rst_mid_b7w31", 3'd7, 8'hFF);
        rd("rst_mid_b1w5", 3'd1, 8'h25);
        wr(8'h5A, 8'hDE, 8'hAD);
        rd("rst_wr_ignored", 3'd2, 8'h5A);
        @(negedge clk);
        rst_n = 1'b1;
        rd("rst_released", 3'd2, 8'h5A);
        wr(8'h5A, 8'hBE, 8'hEF);
        rd("post_rst_wr", 3'd2, 8'h5A);
        MemR_Addr = 3'd2;
        MemW_Addr = 8'h5A;
        #1;
        check_eq("post_rst_const", MemR_Data, 16'hBEEF);
        rd("post_rst_other", 3'd4, 8'h9A);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_256x16.md
MEM_256X16 -- requirements
Module: mem_256x16

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  single system clock; all writes occur on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 MemW_Addr  input  8  shared address; [7:5] selects the RAM pair (bank 0-7), [4:0] selects the word (0-31) within that bank.
REQ-005 MemW_Data_f  input  8 (indexed [15:8])  write data, upper (front) byte.
REQ-006 MemW_Data_b  input  8 ([7:0])  write data, lower (back) byte.
REQ-007 MemW_en  input  1  write enable, active-high.
REQ-008 MemR_Addr  input  3  read bank select (0-7).
REQ-009 MemR_Data  output  16  read data {front byte, back byte}.

Function
REQ-010 Storage SHALL be 8 RAM pairs; each pair is a 32x8 front RAM and a 32x8 back RAM, giving 256 words of 16 bits in total.
REQ-011 On each rising clk edge with rst_n high and MemW_en=1:
- front RAM[MemW_Addr[7:5]][MemW_Addr[4:0]] SHALL load MemW_Data_f.
- back RAM of the same bank and word SHALL load MemW_Data_b.
REQ-012 With MemW_en=0, no storage location SHALL change.
REQ-013 Exactly one word SHALL be written per enabled edge; all other banks and words SHALL be unaffected.
REQ-014 Reads SHALL be combinational (zero latency).
- MemR_Data SHALL equal {front[MemR_Addr][MemW_Addr[4:0]], back[MemR_Addr][MemW_Addr[4:0]]}.
- MemR_Data SHALL track changes on MemR_Addr, MemW_Addr[4:0] and memory contents within the same cycle.
REQ-015 The read bank (MemR_Addr) SHALL be independent of the write bank (MemW_Addr[7:5]).
- The read word index SHALL always be MemW_Addr[4:0].
- MemW_Addr[7:5] SHALL NOT affect the read path.
REQ-016 Write and read to the same location in one cycle:
- before the edge, MemR_Data SHALL show the old value;
- after the edge, MemR_Data SHALL show the new value, with no clock of read latency.
REQ-017 Address boundaries:
- 8'h00 maps to bank 0, word 0.
- 8'hFF maps to bank 7, word 31.
- Addresses SHALL NOT wrap or alias across banks.
REQ-018 The block SHALL produce no X on MemR_Data for any address once reset has been applied.

Reset
REQ-019 When rst_n is low:
- all 256 words (front and back) SHALL be cleared to 8'h00 asynchronously;
- MemR_Data SHALL read 16'h0000 for every address;
- writes SHALL be ignored.
REQ-020 Reset asserted mid-operation SHALL override any write in the same cycle.
REQ-021 Normal writes SHALL resume on the first rising clk edge after rst_n returns high.

Verification
REQ-022 Full fill and readback:
- Stimulus: write {bank, word} = {i[7:0], j[7:0]} to every bank i (0-7) and word j (0-31); then, with MemW_en=0, set MemR_Addr=i and MemW_Addr={i,j}.
- Required response: MemR_Data == {i, j} at every address, e.g. bank 3, word 17 -> 16'h0311.
REQ-023 First location:
- Stimulus: write f=8'hFF, b=8'hFF at MemW_Addr=8'h00.
- Required response: MemR_Addr=0, MemW_Addr=8'h00 reads 16'hFFFF.
REQ-024 Last location:
- Stimulus: write f=8'h55, b=8'hAA at MemW_Addr=8'hFF.
- Required response: MemR_Addr=7, MemW_Addr=8'hFF reads 16'h55AA.
REQ-025 Bank switching:
- Stimulus: for i=0..7, write f=8'hA0+i, b=8'h0A at {i, 5'h0A}, then drop MemW_en and set MemR_Addr=i.
- Required response: MemR_Data == {8'hA0+i, 8'h0A} in the same cycle.
- Other banks' word 10 SHALL remain unchanged.
REQ-026 Write disabled:
- Stimulus: MemW_en=0 with new data and address applied for several edges.
- Required response: stored contents unchanged.
REQ-027 Reset:
- Stimulus: after a fill, pulse rst_n low between clock edges.
- Required response: every location reads 16'h0000 immediately; a write during reset has no effect; a write after release is stored.
